// File: rtl/keypad_pkg.sv
// Shared types and key-code lookup for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } state_t;

   // Indexed [row][col]; '*' encodes as 0xE and '#' as 0xF.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] key_code(input logic [1:0] col_idx, input logic [1:0] row_idx);
      return KEYMAP[row_idx][col_idx];
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      case (v)
         4'b1110: return 2'd0;
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic one_low(input logic [3:0] v);
      return $countones(~v) == 1;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every DIV cycles.
module scan_tick_gen #(
   parameter int unsigned DIV = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick_o = (cnt_q == LAST) && !rst_i;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates active-low columns, debounces press and release,
// and reports each accepted press as a key code with a one-cycle trig.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] value,
   output logic       trig,
   output logic       valid
);

   localparam int unsigned  CW      = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [3:0]    row_meta_q, rs_q;
   logic          tick;
   state_t        state_q;
   logic [3:0]    col_q, pat_q, value_q;
   logic [CW-1:0] cnt_q;
   logic          trig_q, valid_q;
   logic [3:0]    col_d;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         row_meta_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_meta_q <= row;
         rs_q       <= row_meta_q;
      end
   end

   scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
      .clk_i  (clock),
      .rst_i  (reset),
      .tick_o (tick)
   );

   assign col_d = {col_q[2:0], col_q[3]};
   assign cnt_d = (cnt_q == CNT_TGT) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SCAN;
         col_q   <= 4'b1110;
         pat_q   <= 4'hF;
         cnt_q   <= '0;
         value_q <= 4'h0;
         trig_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         trig_q <= 1'b0;
         if (tick) begin
            case (state_q)
               SCAN: begin
                  // Idle and ghosted (multi-row) patterns both keep the scan moving.
                  if (one_low(rs_q)) begin
                     pat_q   <= rs_q;
                     cnt_q   <= '0;
                     state_q <= DEB_PRESS;
                  end else begin
                     col_q <= col_d;
                  end
               end
               DEB_PRESS: begin
                  if (rs_q == pat_q) begin
                     cnt_q <= cnt_d;
                     if (cnt_d == CNT_TGT) begin
                        state_q <= PRESSED;
                        value_q <= key_code(low_idx(col_q), low_idx(pat_q));
                        trig_q  <= 1'b1;
                        valid_q <= 1'b1;
                     end
                  end else begin
                     state_q <= SCAN;
                     col_q   <= col_d;
                  end
               end
               PRESSED: begin
                  if (rs_q == 4'hF) begin
                     cnt_q   <= CNT_ONE;
                     state_q <= DEB_RELEASE;
                  end
               end
               DEB_RELEASE: begin
                  if (rs_q == 4'hF) begin
                     cnt_q <= cnt_d;
                     if (cnt_d == CNT_TGT) begin
                        valid_q <= 1'b0;
                        state_q <= SCAN;
                        col_q   <= col_d;
                     end
                  end else begin
                     state_q <= PRESSED;
                  end
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign col   = col_q;
   assign value = value_q;
   assign valid = valid_q;
   // A reset arriving in the trig cycle kills the pulse without waiting for the edge.
   assign trig  = trig_q & ~reset;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner: a keypad model shorts rows to the low column,
// and key codes come from a character keymap rather than the design's table.
module tb_keypad_scanner;

   localparam int DIV  = 4;
   localparam int DT   = 3;
   localparam int TICK = DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  value;
   logic        trig;
   logic        valid;
   logic [15:0] keys = '0;

   int tests    = 0;
   int fails    = 0;
   int trig_cnt = 0;

   logic [3:0] prev_value = 4'h0;
   logic       prev_trig  = 1'b0;

   always #5 clock = ~clock;

   keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DT)) dut (
      .clock (clock),
      .reset (reset),
      .row   (row),
      .col   (col),
      .value (value),
      .trig  (trig),
      .valid (valid)
   );

   // Pressed key at (r,c) pulls row r low whenever column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_code(input int r, input int c);
      string km = "123A456B789C*0#D";
      int ch = int'(km[r*4+c]);
      if (ch >= 48 && ch <= 57) return 4'(ch - 48);
      if (ch >= 65 && ch <= 68) return 4'(ch - 65 + 10);
      if (ch == 42) return 4'hE;
      return 4'hF;
   endfunction

   function automatic logic [15:0] key_mask(input int r, input int c);
      logic [15:0] m = '0;
      m[r*4+c] = 1'b1;
      return m;
   endfunction

   always @(posedge clock) begin
      #1;
      check("col_onehot", $countones(~col), 1);
      if (trig) begin
         trig_cnt++;
         check("valid_with_trig", valid, 1);
      end
      if (prev_trig) check("trig_width", trig, 0);
      if (value !== prev_value && !reset) check("value_only_with_trig", trig, 1);
      prev_value = value;
      prev_trig  = trig;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press_hold(input int r, input int c, input int hold_ticks, input string tag);
      int t0 = trig_cnt;
      keys = key_mask(r, c);
      cycles(hold_ticks * TICK);
      check({tag, "_trigs"}, trig_cnt - t0, 1);
      check({tag, "_value"}, value, model_code(r, c));
      check({tag, "_valid"}, valid, 1);
   endtask

   // Release takes DT stable ticks: still valid after 10 cycles, cleared by 16.
   task automatic release_all(input string tag);
      int t0 = trig_cnt;
      keys = '0;
      cycles(10);
      check({tag, "_valid_hold"}, valid, 1);
      cycles(6);
      check({tag, "_valid_drop"}, valid, 0);
      cycles(4 * TICK);
      check({tag, "_no_rel_trig"}, trig_cnt - t0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"},   col,   4'b1110);
      check({tag, "_value"}, value, 4'h0);
      check({tag, "_trig"},  trig,  0);
      check({tag, "_valid"}, valid, 0);
   endtask

   initial begin
      int t0;
      logic [3:0] pc;
      int changes;
      int n;

      // Reset and idle rotation
      keys  = '0;
      reset = 1'b1;
      cycles(3);
      reset = 1'b0;
      check_reset_outputs("rst");
      pc = col;
      changes = 0;
      for (int i = 0; i < 16; i++) begin
         cycles(1);
         if (col !== pc) begin
            changes++;
            check("col_rotate", col, {pc[2:0], pc[3]});
            pc = col;
         end
      end
      check("col_rot_count", changes, 4);

      // Key '6' long hold
      press_hold(1, 2, 40, "k6");
      release_all("k6");

      // Key 'D' glitches then stable hold
      t0 = trig_cnt;
      for (int i = 0; i < 5; i++) begin
         keys = key_mask(3, 3);
         cycles(2 * TICK);
         keys = '0;
         cycles(2 * TICK);
      end
      check("kD_glitch_trigs", trig_cnt - t0, 0);
      check("kD_glitch_valid", valid, 0);
      press_hold(3, 3, 40, "kD");
      release_all("kD");

      // Key '5' with release bounce
      t0 = trig_cnt;
      press_hold(1, 1, 20, "k5");
      keys = '0;
      cycles(2 * TICK);
      check("k5_bounce_valid_a", valid, 1);
      keys = key_mask(1, 1);
      cycles(TICK);
      check("k5_bounce_valid_b", valid, 1);
      release_all("k5");
      check("k5_total_trigs", trig_cnt - t0, 1);

      // Ghosting: '1' and '7' share column 0
      t0 = trig_cnt;
      keys = key_mask(0, 0) | key_mask(2, 0);
      cycles(40 * TICK);
      check("ghost_trigs", trig_cnt - t0, 0);
      check("ghost_valid", valid, 0);
      keys = '0;
      cycles(4 * TICK);

      // '1' held, then '#' added: only '1' reported
      t0 = trig_cnt;
      press_hold(0, 0, 20, "k1");
      keys = key_mask(0, 0) | key_mask(3, 2);
      cycles(20 * TICK);
      check("k1hash_trigs", trig_cnt - t0, 1);
      check("k1hash_value", value, model_code(0, 0));
      release_all("k1hash");

      // Reset while debouncing a press
      reset = 1'b1;
      keys  = key_mask(0, 0);
      cycles(3);
      reset = 1'b0;
      t0 = trig_cnt;
      cycles(9);
      reset = 1'b1;
      keys  = '0;
      cycles(1);
      check_reset_outputs("rst_debp");
      check("rst_debp_trigs", trig_cnt - t0, 0);
      reset = 1'b0;
      cycles(4 * TICK);

      // Reset in the trig cycle of an accepted press
      keys = key_mask(0, 1);
      n = 0;
      while (trig !== 1'b1 && n < 60) begin
         cycles(1);
         n++;
      end
      check("press_wait", trig, 1);
      check("k2_value", value, model_code(0, 1));
      reset = 1'b1;
      #1;
      check("trig_suppress", trig, 0);
      cycles(1);
      check_reset_outputs("rst_pressed");
      keys  = '0;
      reset = 1'b0;
      cycles(4 * TICK);

      press_hold(3, 1, 40, "k0");
      release_all("k0");

      // Random single-key episodes and short glitches
      for (int i = 0; i < 10; i++) begin
         int r = $urandom_range(0, 3);
         int c = $urandom_range(0, 3);
         press_hold(r, c, $urandom_range(10, 25), "rnd");
         release_all("rnd");
         t0 = trig_cnt;
         keys = key_mask($urandom_range(0, 3), $urandom_range(0, 3));
         cycles($urandom_range(1, 8));
         keys = '0;
         cycles(6 * TICK);
         check("rnd_glitch_trigs", trig_cnt - t0, 0);
         check("rnd_glitch_valid", valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
